// File: rtl/fp32_cmp_arb.sv
// Round-robin arbiter sharing one combinational fp32 comparator among NUM_REQ requesters.
// Optional unordered-result counter enabled by defining FP32_CMP_ARB_STATS_EN.

module fp32_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt,
  output logic        eq,
  output logic        gt,
  output logic        unord
);
  logic        a_nan;
  logic        b_nan;
  logic        both_zero;
  logic [31:0] key_a;
  logic [31:0] key_b;

  assign a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

  // Map sign-magnitude onto an unsigned total order: negatives inverted, positives offset.
  assign key_a = a[31] ? ~a : {1'b1, a[30:0]};
  assign key_b = b[31] ? ~b : {1'b1, b[30:0]};

  always_comb begin
    lt    = 1'b0;
    eq    = 1'b0;
    gt    = 1'b0;
    unord = 1'b0;
    if (a_nan || b_nan) begin
      unord = 1'b1;
    end else if (both_zero || (a == b)) begin
      eq = 1'b1;
    end else if (key_a < key_b) begin
      lt = 1'b1;
    end else begin
      gt = 1'b1;
    end
  end
endmodule

module fp32_cmp_arb #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef FP32_CMP_ARB_STATS_EN
  input  logic                  stat_clr,
  output logic [15:0]           stat_unord_cnt,
`endif
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic                  resp_lt,
  output logic                  resp_eq,
  output logic                  resp_gt,
  output logic                  resp_unord
);
  // Handshake: a request transfers when req_valid[i] & req_ready[i]; the response
  // transfers when resp_valid & resp_ready. req_ready may depend on req_valid.

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic               can_accept;
  logic               xfer;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic               cmp_lt;
  logic               cmp_eq;
  logic               cmp_gt;
  logic               cmp_unord;

  assign can_accept = !resp_valid || resp_ready;

  // Two passes: first from rr_ptr upward, then wrap from 0.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(rr_ptr))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end

  assign req_ready = grant & {NUM_REQ{can_accept}};
  assign xfer      = |req_ready;

  always_comb begin
    op_a = 32'd0;
    op_b = 32'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_a = req_a[32*i +: 32];
        op_b = req_b[32*i +: 32];
      end
    end
  end

  fp32_cmp u_cmp (
    .a     (op_a),
    .b     (op_b),
    .lt    (cmp_lt),
    .eq    (cmp_eq),
    .gt    (cmp_gt),
    .unord (cmp_unord)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_lt    <= 1'b0;
      resp_eq    <= 1'b0;
      resp_gt    <= 1'b0;
      resp_unord <= 1'b0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      resp_valid <= 1'b1;
      resp_id    <= grant_id;
      resp_lt    <= cmp_lt;
      resp_eq    <= cmp_eq;
      resp_gt    <= cmp_gt;
      resp_unord <= cmp_unord;
      rr_ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef FP32_CMP_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_unord_cnt <= 16'd0;
    end else if (stat_clr) begin
      stat_unord_cnt <= 16'd0;
    end else if (resp_valid && resp_ready && resp_unord && (stat_unord_cnt != 16'hFFFF)) begin
      stat_unord_cnt <= stat_unord_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fp32_cmp_arb.sv
// Directed and randomized checks of fp32_cmp_arb against a real-valued comparison model.
module tb_fp32_cmp_arb;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic            resp_lt;
  logic            resp_eq;
  logic            resp_gt;
  logic            resp_unord;
`ifdef FP32_CMP_ARB_STATS_EN
  logic            stat_clr;
  logic [15:0]     stat_unord_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state: held response as {id, lt, eq, gt, unord}, pointer, last grant.
  logic [5:0]   exp_q[$];
  int           m_rr;
  logic [N-1:0] m_gnt;
  int           m_stat;

  logic [31:0] pool [11] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                             32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hFFFFFFFF,
                             32'h00000001, 32'h80000001, 32'h7F7FFFFF};

  fp32_cmp_arb #(.NUM_REQ(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef FP32_CMP_ARB_STATS_EN
    .stat_clr       (stat_clr),
    .stat_unord_cnt (stat_unord_cnt),
`endif
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_lt        (resp_lt),
    .resp_eq        (resp_eq),
    .resp_gt        (resp_gt),
    .resp_unord     (resp_unord)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real to_real(logic [31:0] x);
    real mag;
    int  e;
    e = int'(x[30:23]);
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
    else             mag = (8388608.0 + real'(x[22:0])) * (2.0 ** (e - 150));
    return x[31] ? -mag : mag;
  endfunction

  // Returns {lt, eq, gt, unord}.
  function automatic logic [3:0] ref_cmp(logic [31:0] a, logic [31:0] b);
    real ra;
    real rb;
    if (is_nan(a) || is_nan(b)) return 4'b0001;
    ra = to_real(a);
    rb = to_real(b);
    if (ra < rb)  return 4'b1000;
    if (ra == rb) return 4'b0100;
    return 4'b0010;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return pool[$urandom_range(0, 10)];
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(125, 129)),
                       23'($urandom_range(0, 3))};
    endcase
  endfunction

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic set_rand_req(int i);
    logic [31:0] a;
    logic [31:0] b;
    a = rand_op();
    case ($urandom_range(0, 7))
      0, 1:    b = a;
      2:       b = a ^ 32'h80000000;
      default: b = rand_op();
    endcase
    set_req(i, a, b);
  endtask

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
  task automatic cycle();
    int           w;
    int           idx;
    bit           can;
    logic [N-1:0] eg;
    logic [31:0]  a;
    logic [31:0]  b;
    #3;
    can = (exp_q.size() == 0) || resp_ready;
    w   = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (w < 0 && ((req_valid >> idx) & 1) != 0) w = idx;
    end
    eg    = (can && w >= 0) ? N'(1 << w) : '0;
    m_gnt = eg;
    chk("req_ready", 32'(req_ready), 32'(eg));
    @(posedge clk);
    #1;
`ifdef FP32_CMP_ARB_STATS_EN
    if (stat_clr) m_stat = 0;
    else if (exp_q.size() != 0 && resp_ready && exp_q[0][0] && m_stat < 65535) m_stat++;
`endif
    if (exp_q.size() != 0 && resp_ready) void'(exp_q.pop_front());
    if (eg != '0) begin
      a = 32'(req_a >> (32 * w));
      b = 32'(req_b >> (32 * w));
      exp_q.push_back({IDW'(w), ref_cmp(a, b)});
      m_rr = (w + 1) % N;
    end
    chk("resp_valid", 32'(resp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("resp_id", 32'(resp_id), 32'(exp_q[0][5:4]));
      chk("resp_flags", {28'd0, resp_lt, resp_eq, resp_gt, resp_unord}, 32'(exp_q[0][3:0]));
    end
`ifdef FP32_CMP_ARB_STATS_EN
    chk("stat_unord_cnt", 32'(stat_unord_cnt), 32'(m_stat));
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
`ifdef FP32_CMP_ARB_STATS_EN
    stat_clr   = 1'b0;
`endif
    m_rr   = 0;
    m_gnt  = '0;
    m_stat = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(resp_valid), 32'd0);
    chk("reset_id", 32'(resp_id), 32'd0);
    chk("reset_flags", {28'd0, resp_lt, resp_eq, resp_gt, resp_unord}, 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request: 1.0 vs 2.0
    set_req(0, 32'h3F800000, 32'h40000000);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    cycle();
    chk("single_flags", {28'd0, resp_lt, resp_eq, resp_gt, resp_unord}, 32'h8);
    chk("single_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    cycle();

    // -inf vs -2.0 and swapped, from requester 3
    set_req(3, 32'hFF800000, 32'hC0000000);
    req_valid = 4'b1000;
    cycle();
    chk("ninf_lt", {28'd0, resp_lt, resp_eq, resp_gt, resp_unord}, 32'h8);
    set_req(3, 32'hC0000000, 32'hFF800000);
    cycle();
    chk("ninf_gt", {28'd0, resp_lt, resp_eq, resp_gt, resp_unord}, 32'h2);

    // Round robin with all requesters active
    for (int i = 0; i < N; i++) set_rand_req(i);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_id", 32'(resp_id), 32'(k % N));
      chk("rr_valid", 32'(resp_valid), 32'd1);
    end

    // Backpressure with requester 2 waiting: -0 vs +0
    req_valid = 4'b0100;
    set_req(2, 32'h80000000, 32'h00000000);
    resp_ready = 1'b0;
    repeat (3) cycle();
    resp_ready = 1'b1;
    cycle();
    chk("bp_eq", {28'd0, resp_lt, resp_eq, resp_gt, resp_unord}, 32'h4);
    chk("bp_id", 32'(resp_id), 32'd2);

    // Asynchronous reset while a response is held
    req_valid  = '0;
    resp_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(resp_valid), 32'd0);
    chk("arst_flags", {28'd0, resp_lt, resp_eq, resp_gt, resp_unord}, 32'd0);
    chk("arst_id", 32'(resp_id), 32'd0);
    exp_q.delete();
    m_rr   = 0;
    m_gnt  = '0;
    m_stat = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h3F800000);
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    cycle();
    chk("arst_first_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    cycle();

    // NaN from requester 1
    set_req(1, 32'h7FC00000, 32'h3F800000);
    req_valid = 4'b0010;
    cycle();
    chk("nan_flags", {28'd0, resp_lt, resp_eq, resp_gt, resp_unord}, 32'h1);
    req_valid = '0;
    cycle();
`ifdef FP32_CMP_ARB_STATS_EN
    chk("stat_one", 32'(stat_unord_cnt), 32'd1);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    chk("stat_cleared", 32'(stat_unord_cnt), 32'd0);
`endif

    // Randomized traffic; requesters hold operands until accepted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (((req_valid >> i) & 1) == 0 || ((m_gnt >> i) & 1) != 0) begin
          if ($urandom_range(0, 2) != 0) begin
            req_valid[i] = 1'b1;
            set_rand_req(i);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
`ifdef FP32_CMP_ARB_STATS_EN
      stat_clr = ($urandom_range(0, 31) == 0);
`endif
      cycle();
    end

    req_valid  = '0;
    resp_ready = 1'b1;
`ifdef FP32_CMP_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
